// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, register index, condition codes
// and the entry record carried through the execute result stage.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  lc3b_nzp;

    // One buffered ALU result together with its write-back controls.
    typedef struct packed {
        lc3b_word data;
        lc3b_reg  dest;
        logic     load_reg;
        logic     load_cc;
        lc3b_nzp  nzp;
    } ex_entry_t;

endpackage

// File: rtl/gencc.sv
// Condition-code generator: classifies a word as negative, zero or positive.
// Purely combinational so load paths can share it.
module gencc
    import lc3b_types::*;
(
    input  lc3b_word data,
    output lc3b_nzp  nzp
);

    logic n;
    logic z;

    assign n   = data[15];
    assign z   = (data == 16'h0000);
    assign nzp = {n, z, ~n & ~z};

endmodule

// File: rtl/ex_result_stage.sv
// Execute result stage: a two-entry skid buffer between the ALU and writeback.
// Both handshake outputs decode registered state only, so out_ready never
// reaches in_ready combinationally. The head entry also drives the
// architectural condition-code register when it retires.
module ex_result_stage
    import lc3b_types::*;
#(
    parameter lc3b_nzp CC_RESET = 3'b010
)
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  lc3b_word in_data,
    input  lc3b_reg  in_dest,
    input  logic     in_load_reg,
    input  logic     in_load_cc,
    output logic     out_valid,
    input  logic     out_ready,
    output lc3b_word out_data,
    output lc3b_reg  out_dest,
    output logic     out_load_reg,
    output logic     out_load_cc,
    output lc3b_nzp  out_nzp,
    output lc3b_nzp  cc
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] state;
    ex_entry_t  main_q;
    ex_entry_t  skid_q;
    ex_entry_t  in_entry;
    lc3b_nzp    in_nzp;
    logic       in_fire;
    logic       out_fire;

    gencc u_gencc (
        .data (in_data),
        .nzp  (in_nzp)
    );

    assign in_entry = '{data: in_data, dest: in_dest, load_reg: in_load_reg,
                        load_cc: in_load_cc, nzp: in_nzp};

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // The head entry always lives in main_q, so outputs stay put while stalled.
    assign out_data     = main_q.data;
    assign out_dest     = main_q.dest;
    assign out_load_reg = main_q.load_reg;
    assign out_load_cc  = main_q.load_cc;
    assign out_nzp      = main_q.nzp;

    // Buffer occupancy and entry movement: capture, replace, spill to skid, refill from skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            // NOTE: the payload registers are reset too (not just state) so the
            // out_* fields read as zero rather than X before the first capture.
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values of state/main_q/skid_q regardless of order.
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_entry;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire) begin
                        if (out_fire) begin
                            main_q <= in_entry;
                        end else begin
                            skid_q <= in_entry;
                            state  <= ST_TWO;
                        end
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Condition codes follow the retiring head entry unless it is being flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc <= CC_RESET;
        end else if (out_fire && main_q.load_cc && !flush) begin
            cc <= main_q.nzp;
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed scenarios plus a randomized run, all
// checked against a queue-based model of a two-deep FIFO with a cc register.
module tb_ex_result_stage;
    import lc3b_types::*;

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     flush = 1'b0;
    logic     in_valid = 1'b0;
    logic     in_ready;
    lc3b_word in_data = '0;
    lc3b_reg  in_dest = '0;
    logic     in_load_reg = 1'b0;
    logic     in_load_cc = 1'b0;
    logic     out_valid;
    logic     out_ready = 1'b0;
    lc3b_word out_data;
    lc3b_reg  out_dest;
    logic     out_load_reg;
    logic     out_load_cc;
    lc3b_nzp  out_nzp;
    lc3b_nzp  cc;

    int n_cmp = 0;
    int n_fail = 0;

    ex_entry_t mq[$];
    lc3b_nzp   mcc = 3'b010;

    always #5 clk = ~clk;

    ex_result_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_load_reg(in_load_reg), .in_load_cc(in_load_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_load_reg(out_load_reg), .out_load_cc(out_load_cc),
        .out_nzp(out_nzp), .cc(cc)
    );

    logic [28:0] obs;
    assign obs = {out_valid, in_ready, cc, out_data, out_dest, out_load_reg, out_load_cc, out_nzp};

    function automatic lc3b_nzp ref_nzp(input lc3b_word d);
        if (d == 16'd0) return 3'b010;
        else if (d >= 16'h8000) return 3'b100;
        else return 3'b001;
    endfunction

    function automatic logic [28:0] model_exp();
        ex_entry_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        return {mq.size() > 0, mq.size() < 2, mcc, h.data, h.dest, h.load_reg, h.load_cc, h.nzp};
    endfunction

    // Head fields are only meaningful while the model holds an entry.
    function automatic logic [28:0] model_mask();
        return (mq.size() > 0) ? '1 : {5'b11111, 24'd0};
    endfunction

    // Drive one cycle of stimulus, clock it, and advance the model.
    task automatic step(input logic rst, input logic fl, input logic iv, input lc3b_word d,
                        input lc3b_reg dst, input logic lr, input logic lc, input logic ordy);
        bit        in_f;
        bit        out_f;
        ex_entry_t e;
        reset = rst; flush = fl; in_valid = iv; in_data = d;
        in_dest = dst; in_load_reg = lr; in_load_cc = lc; out_ready = ordy;
        in_f = iv && (mq.size() < 2);
        out_f = ordy && (mq.size() > 0);
        e = '{data: d, dest: dst, load_reg: lr, load_cc: lc, nzp: ref_nzp(d)};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mcc = 3'b010;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (out_f) begin
                if (mq[0].load_cc) mcc = mq[0].nzp;
                void'(mq.pop_front());
            end
            if (in_f) mq.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_handshake: got valid/ready %b%b want 01", out_valid, in_ready);
        end
        n_cmp++;
        if (cc !== 3'b010) begin
            n_fail++; $display("FAIL reset_cc: got %b want 010", cc);
        end
        n_cmp++;
        if ({out_data, out_dest, out_load_reg, out_load_cc, out_nzp} !== 24'd0) begin
            n_fail++; $display("FAIL reset_fields: got %h/%h/%b/%b/%b want all zero",
                               out_data, out_dest, out_load_reg, out_load_cc, out_nzp);
        end
        idle(1'b0);
    endtask

    task automatic test_negative_cc();
        step(1'b0, 1'b0, 1'b1, 16'h8000, 3'd3, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_nzp !== 3'b100 || out_data !== 16'h8000) begin
            n_fail++; $display("FAIL neg_latency: got valid %b nzp %b data %h want 1 100 8000",
                               out_valid, out_nzp, out_data);
        end
        idle(1'b1);
        n_cmp++;
        if (cc !== 3'b100) begin
            n_fail++; $display("FAIL neg_cc: got %b want 100", cc);
        end
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 3'd2, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        idle(1'b0);
        n_cmp++;
        if (out_data !== 16'h0000 || out_nzp !== 3'b010 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_stall_head: got %h nzp %b valid %b want 0000 010 1",
                               out_data, out_nzp, out_valid);
        end
        idle(1'b1);
        n_cmp++;
        if (out_data !== 16'h0005 || out_nzp !== 3'b001 || out_dest !== 3'd2) begin
            n_fail++; $display("FAIL bp_second: got %h nzp %b dest %0d want 0005 001 2",
                               out_data, out_nzp, out_dest);
        end
        idle(1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || cc !== 3'b001) begin
            n_fail++; $display("FAIL bp_drain: got valid %b cc %b want 0 001", out_valid, cc);
        end
    endtask

    task automatic test_back_to_back();
        lc3b_word d;
        int       bad = 0;
        step(1'b0, 1'b0, 1'b1, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            d = lc3b_word'($urandom);
            step(1'b0, 1'b0, 1'b1, d, lc3b_reg'(i), 1'b1, 1'(i), 1'b1);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== d || out_nzp !== ref_nzp(d)) begin
                n_fail++; bad++;
                $display("FAIL b2b_%0d: got valid %b ready %b data %h nzp %b want 1 1 %h %b",
                         i, out_valid, in_ready, out_data, out_nzp, d, ref_nzp(d));
            end
        end
        idle(1'b1);
        n_cmp++;
        if ((obs & model_mask()) !== (model_exp() & model_mask())) begin
            n_fail++; $display("FAIL b2b_drain: got %h want %h", obs, model_exp());
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 1'b1, 16'h0001, 3'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h8000, 3'd5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h8001, 3'd6, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cc !== 3'b001) begin
            n_fail++; $display("FAIL flush_state: got valid %b ready %b cc %b want 0 1 001",
                               out_valid, in_ready, cc);
        end
        idle(1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || cc !== 3'b001) begin
            n_fail++; $display("FAIL flush_drop: got valid %b cc %b want 0 001", out_valid, cc);
        end
    endtask

    task automatic test_no_cc();
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (out_nzp !== 3'b100 || out_load_cc !== 1'b0) begin
            n_fail++; $display("FAIL nocc_nzp: got nzp %b load_cc %b want 100 0", out_nzp, out_load_cc);
        end
        idle(1'b1);
        n_cmp++;
        if (cc !== 3'b001 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL nocc_cc: got cc %b valid %b want 001 0", cc, out_valid);
        end
    endtask

    task automatic test_reset_in_two();
        step(1'b0, 1'b0, 1'b1, 16'h8000, 3'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0007, 3'd2, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst2_full: got in_ready %b want 0", in_ready);
        end
        step(1'b1, 1'b1, 1'b1, 16'h4444, 3'd3, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cc !== 3'b010 || out_data !== 16'h0000) begin
            n_fail++; $display("FAIL rst2_state: got valid %b ready %b cc %b data %h want 0 1 010 0000",
                               out_valid, in_ready, cc, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 5) == 0) ? 16'h0000 : lc3b_word'($urandom),
                 lc3b_reg'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0);
            n_cmp++;
            if ((obs & model_mask()) !== (model_exp() & model_mask())) begin
                n_fail++; $display("FAIL random_%0d: got %h want %h (mask %h)",
                                   i, obs, model_exp(), model_mask());
            end
        end
    endtask

    initial begin
        test_reset();
        test_negative_cc();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_no_cc();
        test_reset_in_two();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
